multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle MIPS datapath.
- Sequences one instruction through fetch, decode, execute, memory and write-back by driving the write-enables and mux selects around the unconditional IR/DR/A/B/ALUOut data latches.
- Supports wait-state handshaking with a single shared instruction/data memory.
- Halts on the halt opcode or on an illegal encoding.

Parameters:
- PC_INC, 4, byte increment applied to the PC at fetch; drives the alusrc_b=01 constant path.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset: 0 resets the block, 1 runs it.
- op  in  6  IR[31:26], valid from ID onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (combinational).
- mem_rdy  in  1  memory completes the current access this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- rf_we  out  1  register-file write enable.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- alusrc_a  out  1  ALU A select: 0=PC, 1=A latch.
- alusrc_b  out  2  ALU B select: 00=B, 01=PC_INC, 10=ext(imm), 11=ext(imm)<<2.
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- ext_sel  out  1  imm extension: 0=zero, 1=sign.
- reg_dst  out  1  write register: 0=rt, 1=rd.
- mem_to_reg  out  1  write data: 0=ALUOut, 1=DR.
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}.
- halted  out  1  high in HALT.
- ill_op  out  1  high in HALT when entry was caused by an illegal encoding.
- state  out  4  current state code, for debug.

Behaviour:
- States and codes: INIT=0, IF=1, ID=2, EXE_R=3, EXE_I=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_R=8, WB_I=9, WB_LW=10, BR=11, JMP=12, HALT=13.
- Reset:
  - rst=0 forces INIT immediately, asynchronously, including mid-instruction; ill_op flag clears.
  - In INIT every output is 0 except state.
  - First rising clk with rst=1 moves INIT to IF.
- Outputs are decoded from state. Exceptions: ir_we and pc_we in IF, and pc_we in BR, are qualified as stated below.
- Any output not listed for a state is 0.
- IF:
  - Outputs: mem_re=1, iord=0, alusrc_a=0, alusrc_b=01, alu_op=add, pc_src=00.
  - ir_we=pc_we=mem_rdy.
  - Holds while mem_rdy=0; goes to ID when mem_rdy=1.
- ID:
  - Outputs: alusrc_a=0, alusrc_b=11, ext_sel=1, alu_op=add. The branch target lands in ALUOut.
  - Decode by op:
    - 000000 with legal funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) → EXE_R.
    - 001000 addi, 001101 ori → EXE_I.
    - 100011 lw, 101011 sw → ADDR.
    - 000100 beq, 000101 bne → BR.
    - 000010 j → JMP.
    - 111111 → HALT.
    - Anything else, including an illegal funct → HALT with ill_op set.
- EXE_R: alusrc_a=1, alusrc_b=00, alu_op from funct → WB_R.
- EXE_I: alusrc_a=1, alusrc_b=10, alu_op=add (addi) or or (ori), ext_sel=1 for addi and 0 for ori → WB_I.
- ADDR: alusrc_a=1, alusrc_b=10, ext_sel=1, alu_op=add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_re=1, iord=1. Holds until mem_rdy=1, then → WB_LW; DR captures data on that edge.
- MEM_WR: mem_we=1, iord=1. Holds until mem_rdy=1, then → IF.
- WB_R: rf_we=1, reg_dst=1, mem_to_reg=0 → IF.
- WB_I: rf_we=1, reg_dst=0, mem_to_reg=0 → IF.
- WB_LW: rf_we=1, reg_dst=0, mem_to_reg=1 → IF.
- BR:
  - Outputs: alusrc_a=1, alusrc_b=00, alu_op=sub, pc_src=01.
  - pc_we=zero for beq, pc_we=~zero for bne.
  - → IF.
- JMP: pc_we=1, pc_src=10 → IF.
- HALT: halted=1, ill_op per entry cause. Stays until reset.
- Latency with mem_rdy always 1: R-type and I-type 4 cycles, lw 5, sw 4, beq/bne/j 3.
- Each memory wait cycle adds exactly 1 cycle.
- No write-enable pulses while waiting: pc_we and ir_we stay 0 until the mem_rdy cycle.
- At most one of mem_re and mem_we is high in any cycle.
- rf_we is never high in the same cycle as mem_we.

Test Plan:
- Reset held low for 3 cycles mid-EXE_R, then released → all outputs 0 in INIT; state=1 one cycle later; no rf_we pulse from the aborted instruction.
- op=000000, funct=100010, mem_rdy=1 → state sequence 1,2,3,8,1; alu_op=001 in EXE_R; one rf_we pulse with reg_dst=1.
- lw with mem_rdy low for 2 cycles in IF and 1 cycle in MEM_RD → 8 cycles total; ir_we exactly one pulse, aligned with mem_rdy; rf_we with mem_to_reg=1 in WB_LW.
- beq with zero=1, then bne with zero=1 → pc_we=1 with pc_src=01 for the first; pc_we=0 for the second; both return to IF after 3 cycles.
- sw with mem_rdy=1 → mem_we=1 and iord=1 for exactly 1 cycle; rf_we never asserted.
- op=000000 with funct=000111, then op=111111 after reset → both reach HALT with halted=1; ill_op=1 for the first, ill_op=0 for the second; no pc_we afterwards.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back around the IR/DR/A/B/ALUOut latches.
module multicycle_ctrl #(
    parameter int unsigned PC_INC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_we,
    output logic       ir_we,
    output logic       rf_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [2:0] alu_op,
    output logic       ext_sel,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       halted,
    output logic       ill_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_INIT  = 4'd0;
    localparam logic [3:0] S_IF    = 4'd1;
    localparam logic [3:0] S_ID    = 4'd2;
    localparam logic [3:0] S_EXE_R = 4'd3;
    localparam logic [3:0] S_EXE_I = 4'd4;
    localparam logic [3:0] S_ADDR  = 4'd5;
    localparam logic [3:0] S_MEMRD = 4'd6;
    localparam logic [3:0] S_MEMWR = 4'd7;
    localparam logic [3:0] S_WB_R  = 4'd8;
    localparam logic [3:0] S_WB_I  = 4'd9;
    localparam logic [3:0] S_WB_LW = 4'd10;
    localparam logic [3:0] S_BR    = 4'd11;
    localparam logic [3:0] S_JMP   = 4'd12;
    localparam logic [3:0] S_HALT  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // The PC increment is applied by the datapath through alusrc_b=01.
    if (PC_INC == 0) begin : g_bad_pc_inc
        $error("multicycle_ctrl: PC_INC must be nonzero");
    end

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_ill;
    logic       w_ill_next;
    logic       w_funct_ok;
    logic [2:0] w_funct_aop;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_aop = ALU_ADD;
        case (funct)
            6'b100000: w_funct_aop = ALU_ADD;
            6'b100010: w_funct_aop = ALU_SUB;
            6'b100100: w_funct_aop = ALU_AND;
            6'b100101: w_funct_aop = ALU_OR;
            6'b101010: w_funct_aop = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_ill_next = r_ill;
        case (r_state)
            S_INIT:  w_next = S_IF;
            S_IF:    if (mem_rdy) w_next = S_ID;
            S_ID: begin
                case (op)
                    OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = S_EXE_R;
                        end else begin
                            w_next     = S_HALT;
                            w_ill_next = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ORI: w_next = S_EXE_I;
                    OP_LW, OP_SW:    w_next = S_ADDR;
                    OP_BEQ, OP_BNE:  w_next = S_BR;
                    OP_J:            w_next = S_JMP;
                    OP_HALT: begin
                        w_next     = S_HALT;
                        w_ill_next = 1'b0;
                    end
                    default: begin
                        w_next     = S_HALT;
                        w_ill_next = 1'b1;
                    end
                endcase
            end
            S_EXE_R: w_next = S_WB_R;
            S_EXE_I: w_next = S_WB_I;
            S_ADDR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: if (mem_rdy) w_next = S_WB_LW;
            S_MEMWR: if (mem_rdy) w_next = S_IF;
            S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP: w_next = S_IF;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ill   <= w_ill_next;
        end
    end

    // Outputs depend on state only, except the fetch/branch write-enables,
    // which are gated so nothing is written while memory is stalling.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        alusrc_a   = 1'b0;
        alusrc_b   = 2'b00;
        alu_op     = ALU_ADD;
        ext_sel    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        halted     = 1'b0;
        ill_op     = 1'b0;
        state      = r_state;
        case (r_state)
            S_IF: begin
                mem_re   = 1'b1;
                alusrc_b = 2'b01;
                ir_we    = mem_rdy;
                pc_we    = mem_rdy;
            end
            S_ID: begin
                alusrc_b = 2'b11;
                ext_sel  = 1'b1;
            end
            S_EXE_R: begin
                alusrc_a = 1'b1;
                alu_op   = w_funct_aop;
            end
            S_EXE_I: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                if (op == OP_ORI) begin
                    alu_op = ALU_OR;
                end else begin
                    ext_sel = 1'b1;
                end
            end
            S_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                ext_sel  = 1'b1;
            end
            S_MEMRD: begin
                mem_re = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
            end
            S_WB_R: begin
                rf_we   = 1'b1;
                reg_dst = 1'b1;
            end
            S_WB_I:  rf_we = 1'b1;
            S_WB_LW: begin
                rf_we      = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BR: begin
                alusrc_a = 1'b1;
                alu_op   = ALU_SUB;
                pc_src   = 2'b01;
                pc_we    = (op == OP_BEQ) ? zero : ~zero;
            end
            S_JMP: begin
                pc_we  = 1'b1;
                pc_src = 2'b10;
            end
            S_HALT: begin
                halted = 1'b1;
                ill_op = r_ill;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       mem_re;
        logic       mem_we;
        logic       iord;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       halted;
        logic       ill_op;
        logic [3:0] state;
    } outs_t;

    localparam logic [3:0] S_INIT = 4'd0,  S_IF = 4'd1,  S_ID = 4'd2,  S_EXR = 4'd3;
    localparam logic [3:0] S_EXI  = 4'd4,  S_ADDR = 4'd5, S_MRD = 4'd6, S_MWR = 4'd7;
    localparam logic [3:0] S_WBR  = 4'd8,  S_WBI = 4'd9, S_WBLW = 4'd10, S_BR = 4'd11;
    localparam logic [3:0] S_JMP  = 4'd12, S_HALT = 4'd13;

    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, JOP = 6'b000010, HLT = 6'b111111;
    localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_BAD = 6'b000111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       chk_evt = 1'b0;
    outs_t      act;
    outs_t      q[$];
    int         checks = 0;
    int         errors = 0;

    multicycle_ctrl #(.PC_INC(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .pc_we(act.pc_we), .ir_we(act.ir_we), .rf_we(act.rf_we),
        .mem_re(act.mem_re), .mem_we(act.mem_we), .iord(act.iord),
        .alusrc_a(act.alusrc_a), .alusrc_b(act.alusrc_b), .alu_op(act.alu_op),
        .ext_sel(act.ext_sel), .reg_dst(act.reg_dst), .mem_to_reg(act.mem_to_reg),
        .pc_src(act.pc_src), .halted(act.halted), .ill_op(act.ill_op), .state(act.state)
    );

    always #5 clk = ~clk;

    function automatic outs_t exp_outs(input logic [3:0] st, input logic [5:0] o,
                                       input logic [5:0] f, input logic z,
                                       input logic r, input logic il);
        outs_t e;
        e = '0;
        e.state = st;
        case (st)
            S_IF:   begin e.mem_re = 1; e.alusrc_b = 2'b01; e.ir_we = r; e.pc_we = r; end
            S_ID:   begin e.alusrc_b = 2'b11; e.ext_sel = 1; end
            S_EXR:  begin
                e.alusrc_a = 1;
                e.alu_op = (f == F_SUB) ? 3'b001 : (f == F_SLT) ? 3'b100 : 3'b000;
            end
            S_EXI:  begin
                e.alusrc_a = 1; e.alusrc_b = 2'b10;
                if (o == ORI) e.alu_op = 3'b011; else e.ext_sel = 1;
            end
            S_ADDR: begin e.alusrc_a = 1; e.alusrc_b = 2'b10; e.ext_sel = 1; end
            S_MRD:  begin e.mem_re = 1; e.iord = 1; end
            S_MWR:  begin e.mem_we = 1; e.iord = 1; end
            S_WBR:  begin e.rf_we = 1; e.reg_dst = 1; end
            S_WBI:  e.rf_we = 1;
            S_WBLW: begin e.rf_we = 1; e.mem_to_reg = 1; end
            S_BR:   begin
                e.alusrc_a = 1; e.alu_op = 3'b001; e.pc_src = 2'b01;
                e.pc_we = (o == BEQ) ? z : ~z;
            end
            S_JMP:  begin e.pc_we = 1; e.pc_src = 2'b10; end
            S_HALT: begin e.halted = 1; e.ill_op = il; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_outs(input string tag, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                         input logic z = 1'b0, input logic r = 1'b1, input logic il = 1'b0);
        op = o; funct = f; zero = z; mem_rdy = r;
        q.push_back(exp_outs(st, o, f, z, r, il));
    endtask

    task automatic step(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                        input logic z = 1'b0, input logic r = 1'b1, input logic il = 1'b0);
        drive(st, o, f, z, r, il);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk or posedge chk_evt) begin
        if (q.size() > 0) begin
            outs_t e;
            e = q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outs st%0d @%0t: got %h expected %h", e.state, $time, act, e);
            end
        end
    end

    initial begin
        outs_t w;
        @(posedge clk);
        #1;
        step(S_INIT, RT, F_SUB);
        step(S_INIT, RT, F_SUB);
        rst = 1'b1;
        step(S_INIT, RT, F_SUB);
        step(S_IF, RT, F_SUB);
        step(S_ID, RT, F_SUB);
        drive(S_EXR, RT, F_SUB);
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(S_INIT, RT, F_SUB);
        #1 chk_evt = 1'b1;
        check_outs("reset_state", act, outs_t'(0));
        #1 chk_evt = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(S_INIT, RT, F_SUB);
        rst = 1'b1;
        step(S_INIT, RT, F_SUB);
        step(S_IF, RT, F_SUB);
        step(S_ID, RT, F_SUB);
        step(S_EXR, RT, F_SUB);
        step(S_WBR, RT, F_SUB);
        step(S_IF, LW, 6'h00, 0, 0);
        step(S_IF, LW, 6'h00, 0, 0);
        drive(S_IF, LW, 6'h00, 0, 1);
        #2;
        w = '0;
        w.state = S_IF; w.mem_re = 1; w.alusrc_b = 2'b01; w.ir_we = 1; w.pc_we = 1;
        check_outs("wait_expired", act, w);
        @(posedge clk);
        #1;
        step(S_ID, LW, 6'h00);
        step(S_ADDR, LW, 6'h00);
        step(S_MRD, LW, 6'h00, 0, 0);
        step(S_MRD, LW, 6'h00, 0, 1);
        step(S_WBLW, LW, 6'h00);
        step(S_IF, BEQ, 6'h00, 1);
        step(S_ID, BEQ, 6'h00, 1);
        step(S_BR, BEQ, 6'h00, 1);
        step(S_IF, BNE, 6'h00, 1);
        step(S_ID, BNE, 6'h00, 1);
        step(S_BR, BNE, 6'h00, 1);
        step(S_IF, SW, 6'h00);
        step(S_ID, SW, 6'h00);
        step(S_ADDR, SW, 6'h00);
        step(S_MWR, SW, 6'h00);
        step(S_IF, ADDI, 6'h3f);
        step(S_ID, ADDI, 6'h3f);
        step(S_EXI, ADDI, 6'h3f);
        step(S_WBI, ADDI, 6'h3f);
        step(S_IF, ORI, 6'h00);
        step(S_ID, ORI, 6'h00);
        step(S_EXI, ORI, 6'h00);
        step(S_WBI, ORI, 6'h00);
        step(S_IF, RT, F_SLT);
        step(S_ID, RT, F_SLT);
        step(S_EXR, RT, F_SLT);
        step(S_WBR, RT, F_SLT);
        step(S_IF, JOP, 6'h00);
        step(S_ID, JOP, 6'h00);
        step(S_JMP, JOP, 6'h00);
        step(S_IF, RT, F_BAD);
        step(S_ID, RT, F_BAD);
        step(S_HALT, RT, F_BAD, 1, 1, 1);
        step(S_HALT, RT, F_BAD, 1, 1, 1);
        step(S_HALT, RT, F_BAD, 0, 1, 1);
        rst = 1'b0;
        step(S_INIT, HLT, 6'h00);
        rst = 1'b1;
        step(S_INIT, HLT, 6'h00);
        step(S_IF, HLT, 6'h00);
        step(S_ID, HLT, 6'h00);
        step(S_HALT, HLT, 6'h00, 1, 1, 0);
        step(S_HALT, HLT, 6'h00, 0, 1, 0);
        rst = 1'b0;
        step(S_INIT, 6'b000001, 6'h00);
        rst = 1'b1;
        step(S_INIT, 6'b000001, 6'h00);
        step(S_IF, 6'b000001, 6'h00);
        step(S_ID, 6'b000001, 6'h00);
        step(S_HALT, 6'b000001, 6'h00, 0, 1, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
